// File: rtl/float_clamp_arbiter_if.sv
// Stream bundle for float_clamp_arbiter: per-requester operands, the shared-unit
// operand/result streams and the tagged result stream.
interface float_clamp_arbiter_if #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned NUM_REQ = 3
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ*SIZE-1:0] s_req_tdata;
    logic [NUM_REQ-1:0]      s_req_tvalid;
    logic [NUM_REQ-1:0]      s_req_tready;
    logic [SIZE-1:0]         m_unit_tdata;
    logic                    m_unit_tvalid;
    logic                    m_unit_tready;
    logic [SIZE-1:0]         s_unit_tdata;
    logic                    s_unit_tvalid;
    logic                    s_unit_tready;
    logic [SIZE-1:0]         m_result_tdata;
    logic [IDW-1:0]          m_result_tid;
    logic                    m_result_tvalid;
    logic                    m_result_tready;

    modport slave (
        input  s_req_tdata, s_req_tvalid, m_unit_tready, s_unit_tdata, s_unit_tvalid, m_result_tready,
        output s_req_tready, m_unit_tdata, m_unit_tvalid, s_unit_tready,
               m_result_tdata, m_result_tid, m_result_tvalid
    );

    modport master (
        output s_req_tdata, s_req_tvalid, m_unit_tready, s_unit_tdata, s_unit_tvalid, m_result_tready,
        input  s_req_tready, m_unit_tdata, m_unit_tvalid, s_unit_tready,
               m_result_tdata, m_result_tid, m_result_tvalid
    );
endinterface

// File: rtl/float_clamp_arbiter.sv
// Round-robin arbiter sharing one in-order clamp unit among NUM_REQ requesters,
// tagging results by requester. Define CLAMP_ARB_STATS_EN for per-requester grant counters.
module float_clamp_arbiter #(
    parameter int unsigned SIZE      = 32,
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    float_clamp_arbiter_if.slave  bus,
    output logic                  busy
`ifdef CLAMP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_count
`endif
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(TAG_DEPTH + 1);

    logic [IDW-1:0]  rr_q, rr_d, grant, rot_idx;
    logic [IDW:0]    rot_sum;
    logic            found;
    logic            hold_q, hold_d;
    logic [IDW-1:0]  hold_g_q, hold_g_d;
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  tag_mem [TAG_DEPTH];
    logic [SIZE-1:0] req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    logic            tag_full, tag_empty, unit_valid, push, pop;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign req_data[i] = bus.s_req_tdata[i*SIZE +: SIZE];
    end

    assign tag_full  = (cnt_q == CW'(TAG_DEPTH));
    assign tag_empty = (cnt_q == '0);

    // Rotating priority search; a stalled offer keeps its grant until it is taken
    // or its requester withdraws, so late higher-priority arrivals cannot steal it.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        rot_sum = '0;
        rot_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rot_sum = {1'b0, rr_q} + (IDW+1)'(i);
            if (rot_sum >= (IDW+1)'(NUM_REQ))
                rot_sum = rot_sum - (IDW+1)'(NUM_REQ);
            rot_idx = rot_sum[IDW-1:0];
            if (!found && bus.s_req_tvalid[rot_idx]) begin
                grant = rot_idx;
                found = 1'b1;
            end
        end
        if (hold_q && bus.s_req_tvalid[hold_g_q])
            grant = hold_g_q;
    end

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = aresetn & bus.m_unit_tready & ~tag_full;
    end

    assign unit_valid          = aresetn & (|bus.s_req_tvalid) & ~tag_full;
    assign push                = unit_valid & bus.m_unit_tready;
    assign bus.m_unit_tvalid   = unit_valid;
    assign bus.m_unit_tdata    = req_data[grant];
    assign bus.s_req_tready    = req_ready;

    assign bus.m_result_tdata  = bus.s_unit_tdata;
    assign bus.m_result_tid    = tag_mem[rd_q];
    assign bus.m_result_tvalid = aresetn & bus.s_unit_tvalid & ~tag_empty;
    assign bus.s_unit_tready   = aresetn & bus.m_result_tready & ~tag_empty;
    assign pop                 = bus.s_unit_tvalid & bus.s_unit_tready;
    assign busy                = ~tag_empty;

    always_comb begin
        rr_d     = rr_q;
        hold_d   = unit_valid & ~bus.m_unit_tready;
        hold_g_d = grant;
        cnt_d    = cnt_q;
        if (push)
            rr_d = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_q     <= '0;
            hold_q   <= 1'b0;
            hold_g_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            hold_g_q <= hold_g_d;
            cnt_q    <= cnt_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            tag_mem[wr_q] <= grant;
    end

`ifdef CLAMP_ARB_STATS_EN
    logic [15:0] gcnt_q [NUM_REQ];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NUM_REQ; i++)
                gcnt_q[i] <= '0;
        end else if (push && gcnt_q[grant] != '1) begin
            gcnt_q[grant] <= gcnt_q[grant] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        assign grant_count[i*16 +: 16] = gcnt_q[i];
    end
`endif
endmodule

// File: tb/tb_float_clamp_arbiter.sv
// Directed self-checking bench for float_clamp_arbiter (3 requesters, 32-bit, 8 tags).
// The statistics scenario runs only when CLAMP_ARB_STATS_EN is defined.
module tb_float_clamp_arbiter;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] dat [3];
`ifdef CLAMP_ARB_STATS_EN
    logic [47:0] grant_count;
`endif

    float_clamp_arbiter_if #(.SIZE(32), .NUM_REQ(3)) bus ();

    float_clamp_arbiter #(.SIZE(32), .NUM_REQ(3), .TAG_DEPTH(8)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus),
        .busy    (busy)
`ifdef CLAMP_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic idle_inputs();
        bus.s_req_tvalid    = '0;
        bus.s_req_tdata     = {dat[2], dat[1], dat[0]};
        bus.m_unit_tready   = 1'b0;
        bus.s_unit_tvalid   = 1'b0;
        bus.s_unit_tdata    = '0;
        bus.m_result_tready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        idle_inputs();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        idle_inputs();
        bus.s_req_tvalid    = 3'b111;
        bus.m_unit_tready   = 1'b1;
        bus.s_unit_tvalid   = 1'b1;
        bus.m_result_tready = 1'b1;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.m_unit_tvalid !== 1'b0) begin errors++; $display("FAIL reset_unit_tvalid: got %b expected 0", bus.m_unit_tvalid); end
        checks++; if (bus.s_req_tready !== 3'b000) begin errors++; $display("FAIL reset_req_tready: got %b expected 000", bus.s_req_tready); end
        checks++; if (bus.s_unit_tready !== 1'b0) begin errors++; $display("FAIL reset_unit_tready: got %b expected 0", bus.s_unit_tready); end
        checks++; if (bus.m_result_tvalid !== 1'b0) begin errors++; $display("FAIL reset_result_tvalid: got %b expected 0", bus.m_result_tvalid); end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_fairness();
        do_reset();
        bus.s_req_tvalid    = 3'b111;
        bus.m_unit_tready   = 1'b1;
        bus.s_unit_tvalid   = 1'b1;
        bus.m_result_tready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (bus.m_unit_tdata !== dat[k%3]) begin errors++; $display("FAIL fair_data[%0d]: got %h expected %h", k, bus.m_unit_tdata, dat[k%3]); end
            checks++; if (bus.s_req_tready !== 3'(1 << (k%3))) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", k, bus.s_req_tready, 3'(1 << (k%3))); end
            if (k > 0) begin
                checks++; if (bus.m_result_tvalid !== 1'b1 || bus.m_result_tid !== 2'((k-1)%3)) begin
                    errors++; $display("FAIL fair_tid[%0d]: got v=%b tid=%0d expected v=1 tid=%0d", k, bus.m_result_tvalid, bus.m_result_tid, (k-1)%3);
                end
            end
            @(negedge aclk);
        end
    endtask

    task automatic test_tag_routing();
        do_reset();
        dat[0] = 32'hC0000000; dat[2] = 32'h44000000;
        bus.s_req_tdata   = {dat[2], dat[1], dat[0]};
        bus.s_unit_tvalid = 1'b1;
        bus.m_result_tready = 1'b1;
        #1;
        checks++; if (bus.m_result_tvalid !== 1'b0 || bus.s_unit_tready !== 1'b0) begin
            errors++; $display("FAIL empty_ignore: got v=%b r=%b expected v=0 r=0", bus.m_result_tvalid, bus.s_unit_tready);
        end
        @(negedge aclk);
        bus.s_unit_tvalid = 1'b0;
        bus.s_req_tvalid  = 3'b100;
        bus.m_unit_tready = 1'b1;
        #1;
        checks++; if (bus.m_unit_tdata !== 32'h44000000 || bus.s_req_tready !== 3'b100) begin
            errors++; $display("FAIL route_issue2: got %h/%b expected 44000000/100", bus.m_unit_tdata, bus.s_req_tready);
        end
        @(negedge aclk);
        bus.s_req_tvalid = 3'b001;
        #1;
        checks++; if (bus.m_unit_tdata !== 32'hC0000000 || bus.s_req_tready !== 3'b001) begin
            errors++; $display("FAIL route_issue0: got %h/%b expected C0000000/001", bus.m_unit_tdata, bus.s_req_tready);
        end
        @(negedge aclk);
        bus.s_req_tvalid  = 3'b000;
        bus.s_unit_tvalid = 1'b1;
        bus.s_unit_tdata  = 32'h437f0000;
        #1;
        checks++; if (bus.m_result_tvalid !== 1'b1 || bus.m_result_tid !== 2'd2 || bus.m_result_tdata !== 32'h437f0000 || bus.s_unit_tready !== 1'b1) begin
            errors++; $display("FAIL route_res1: got v=%b tid=%0d d=%h expected v=1 tid=2 d=437f0000", bus.m_result_tvalid, bus.m_result_tid, bus.m_result_tdata);
        end
        @(negedge aclk);
        bus.s_unit_tdata = 32'h00000000;
        #1;
        checks++; if (bus.m_result_tvalid !== 1'b1 || bus.m_result_tid !== 2'd0 || bus.m_result_tdata !== 32'h00000000) begin
            errors++; $display("FAIL route_res2: got v=%b tid=%0d d=%h expected v=1 tid=0 d=00000000", bus.m_result_tvalid, bus.m_result_tid, bus.m_result_tdata);
        end
        @(negedge aclk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL route_drained: got busy=%b expected 0", busy); end
    endtask

    task automatic test_full();
        do_reset();
        bus.s_req_tvalid  = 3'b001;
        bus.m_unit_tready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            checks++; if (bus.m_unit_tvalid !== 1'b1) begin errors++; $display("FAIL full_issue[%0d]: got %b expected 1", j, bus.m_unit_tvalid); end
            @(negedge aclk);
        end
        #1;
        checks++; if (bus.m_unit_tvalid !== 1'b0 || bus.s_req_tready !== 3'b000 || busy !== 1'b1) begin
            errors++; $display("FAIL full_block: got v=%b r=%b busy=%b expected v=0 r=000 busy=1", bus.m_unit_tvalid, bus.s_req_tready, busy);
        end
        @(negedge aclk);
        bus.s_unit_tvalid   = 1'b1;
        bus.m_result_tready = 1'b1;
        #1;
        checks++; if (bus.m_unit_tvalid !== 1'b0 || bus.s_req_tready !== 3'b000) begin
            errors++; $display("FAIL full_pop_same_cycle: got v=%b r=%b expected v=0 r=000", bus.m_unit_tvalid, bus.s_req_tready);
        end
        checks++; if (bus.m_result_tvalid !== 1'b1 || bus.m_result_tid !== 2'd0) begin
            errors++; $display("FAIL full_pop_tid: got v=%b tid=%0d expected v=1 tid=0", bus.m_result_tvalid, bus.m_result_tid);
        end
        @(negedge aclk);
        bus.s_unit_tvalid = 1'b0;
        #1;
        checks++; if (bus.m_unit_tvalid !== 1'b1 || bus.s_req_tready !== 3'b001) begin
            errors++; $display("FAIL full_resume: got v=%b r=%b expected v=1 r=001", bus.m_unit_tvalid, bus.s_req_tready);
        end
    endtask

    task automatic test_stall();
        dat[0] = 32'h3F800000; dat[1] = 32'h40000000; dat[2] = 32'h40400000;
        do_reset();
        bus.s_req_tvalid  = 3'b110;
        bus.m_unit_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus.s_req_tvalid = 3'b111;
            #1;
            checks++; if (bus.m_unit_tvalid !== 1'b1 || bus.m_unit_tdata !== dat[1] || bus.s_req_tready !== 3'b000) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h r=%b expected v=1 d=%h r=000", c, bus.m_unit_tvalid, bus.m_unit_tdata, bus.s_req_tready, dat[1]);
            end
            @(negedge aclk);
        end
        bus.m_unit_tready = 1'b1;
        #1;
        checks++; if (bus.m_unit_tdata !== dat[1] || bus.s_req_tready !== 3'b010) begin
            errors++; $display("FAIL stall_release: got d=%h r=%b expected d=%h r=010", bus.m_unit_tdata, bus.s_req_tready, dat[1]);
        end
        @(negedge aclk);
        #1;
        checks++; if (bus.m_unit_tdata !== dat[2] || bus.s_req_tready !== 3'b100) begin
            errors++; $display("FAIL stall_next: got d=%h r=%b expected d=%h r=100", bus.m_unit_tdata, bus.s_req_tready, dat[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_g [3];
        exp_g[0] = 2'd1; exp_g[1] = 2'd2; exp_g[2] = 2'd1;
        do_reset();
        bus.s_req_tvalid  = 3'b110;
        bus.m_unit_tready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (bus.m_unit_tdata !== dat[exp_g[j]]) begin
                errors++; $display("FAIL mid_issue[%0d]: got %h expected %h", j, bus.m_unit_tdata, dat[exp_g[j]]);
            end
            @(negedge aclk);
        end
        bus.s_req_tvalid = 3'b111;
        #1;
        checks++; if (busy !== 1'b1 || bus.m_unit_tdata !== dat[2]) begin
            errors++; $display("FAIL mid_pre_reset: got busy=%b d=%h expected busy=1 d=%h", busy, bus.m_unit_tdata, dat[2]);
        end
        aresetn             = 1'b0;
        bus.s_unit_tvalid   = 1'b1;
        bus.m_result_tready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || bus.m_unit_tvalid !== 1'b0 || bus.s_req_tready !== 3'b000 ||
                      bus.m_result_tvalid !== 1'b0 || bus.s_unit_tready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got busy=%b uv=%b rr=%b rv=%b ur=%b expected all 0",
                               busy, bus.m_unit_tvalid, bus.s_req_tready, bus.m_result_tvalid, bus.s_unit_tready);
        end
        @(negedge aclk);
        aresetn             = 1'b1;
        bus.s_unit_tvalid   = 1'b0;
        bus.m_result_tready = 1'b0;
        #1;
        checks++; if (bus.m_unit_tvalid !== 1'b1 || bus.s_req_tready !== 3'b001 || bus.m_unit_tdata !== dat[0] || busy !== 1'b0) begin
            errors++; $display("FAIL mid_first_grant: got v=%b r=%b d=%h busy=%b expected v=1 r=001 d=%h busy=0",
                               bus.m_unit_tvalid, bus.s_req_tready, bus.m_unit_tdata, busy, dat[0]);
        end
    endtask

`ifdef CLAMP_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.s_req_tvalid    = 3'b010;
        bus.m_unit_tready   = 1'b1;
        bus.s_unit_tvalid   = 1'b1;
        bus.m_result_tready = 1'b1;
        for (int n = 0; n < 70000; n++) @(negedge aclk);
        bus.s_req_tvalid = 3'b000;
        #1;
        checks++; if (grant_count !== {16'h0000, 16'hFFFF, 16'h0000}) begin
            errors++; $display("FAIL stats_sat: got %h expected 0000ffff0000", grant_count);
        end
    endtask
`endif

    initial begin
        dat[0] = 32'h3F800000; dat[1] = 32'h40000000; dat[2] = 32'h40400000;
        test_reset();
        test_fairness();
        test_tag_routing();
        test_full();
        test_stall();
        test_reset_mid();
`ifdef CLAMP_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/float_clamp_arbiter.md
FLOAT_CLAMP_ARBITER -- requirements
Module: float_clamp_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 32, float word width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 3, number of requester streams (2..8).
REQ-003 SHALL have parameter TAG_DEPTH, default 8, maximum in-flight transactions in the shared unit (power of 2).
REQ-004 SHALL have port aclk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports s_req_tdata, s_req_tvalid and s_req_tready, input/input/output, NUM_REQ*SIZE / NUM_REQ / NUM_REQ, per-requester operand streams; requester i uses slice i.
REQ-007 SHALL have ports m_unit_tdata, m_unit_tvalid and m_unit_tready, output/output/input, SIZE/1/1, operand stream to the shared clamp unit.
REQ-008 SHALL have ports s_unit_tdata, s_unit_tvalid and s_unit_tready, input/input/output, SIZE/1/1, result stream from the shared clamp unit.
REQ-009 SHALL have ports m_result_tdata, m_result_tid, m_result_tvalid and m_result_tready, output/output/output/input, SIZE/$clog2(NUM_REQ)/1/1, tagged result stream.
REQ-010 SHALL have port busy, output, 1, high while any transaction is in flight.

Function
REQ-011 SHALL arbitrate round-robin: a pointer rr_ptr names the highest-priority requester, and the grant goes to the first valid requester at or after rr_ptr (modulo NUM_REQ).
REQ-012 SHALL drive m_unit_tvalid = (any s_req_tvalid) AND NOT tag_full, with m_unit_tdata = granted requester's data.
REQ-013 SHALL assert s_req_tready[g] = m_unit_tready AND NOT tag_full only for the granted index g; all other bits 0.
REQ-014 SHALL, on a unit-side handshake, push g into the tag FIFO and set rr_ptr to (g+1) mod NUM_REQ in the same cycle.
REQ-015 SHALL hold rr_ptr and the grant stable while m_unit_tvalid=1 and m_unit_tready=0 (no grant change mid-stall).
REQ-016 SHALL pass s_unit_tdata to m_result_tdata combinationally, with m_result_tid = tag FIFO head, m_result_tvalid = s_unit_tvalid AND NOT tag_empty, and s_unit_tready = m_result_tready AND NOT tag_empty.
REQ-017 SHALL pop the tag FIFO on a result-side handshake; tags SHALL return in issue order (the unit is in-order).
REQ-018 SHALL keep an occupancy counter 0..TAG_DEPTH, where tag_full means count==TAG_DEPTH and tag_empty means count==0; simultaneous push and pop leave count unchanged.
REQ-019 SHALL, when full, accept no new issue even if a pop occurs in the same cycle (tag_full is registered state).
REQ-020 SHALL wrap FIFO read and write pointers modulo TAG_DEPTH.
REQ-021 SHALL drive busy = NOT tag_empty.
REQ-022 SHALL ignore s_unit_tvalid while tag_empty; such data is neither forwarded nor acknowledged.

Reset
REQ-023 SHALL, on aresetn=0, immediately clear rr_ptr to 0, FIFO pointers and count to 0, and statistics counters to 0.
REQ-024 SHALL, during reset, drive all tready and tvalid outputs to 0 and busy to 0; in-flight tags SHALL be discarded.
REQ-025 SHALL release reset synchronously to aclk, assuming an externally synchronised deassertion.

Configuration
REQ-026 SHALL, when CLAMP_ARB_STATS_EN is defined, add output grant_count (NUM_REQ*16 bits), holding a per-requester 16-bit count of issued transactions that saturates at 16'hFFFF.
REQ-027 SHALL, when CLAMP_ARB_STATS_EN is undefined, omit the grant_count port and all counter logic, with no other behavioural change.

Verification
REQ-028 SHALL verify fairness: all 3 requesters continuously valid with the unit always ready -> issue order is 0,1,2,0,1,2 for 12 cycles.
REQ-029 SHALL verify tag routing: requester 2 sends 32'h44000000 and requester 0 sends 32'hC0000000, with the unit returning 32'h437f0000 then 32'h00000000 -> tid 2 then tid 0, with data unchanged.
REQ-030 SHALL verify full condition: TAG_DEPTH=8, unit accepts 8 operands, m_result_tready=0 -> 9th not issued and s_req_tready all 0; one pop -> issue resumes the following cycle.
REQ-031 SHALL verify stall hold: m_unit_tready=0 for 5 cycles while requesters 1 and 2 are valid -> grant stays 1 and m_unit_tdata is constant.
REQ-032 SHALL verify reset mid-operation: aresetn asserted with 3 tags in flight -> busy=0 and outputs 0 in the same cycle; after release, the first grant goes to requester 0.
REQ-033 SHALL verify statistics: with CLAMP_ARB_STATS_EN defined, 70000 issues from requester 1 -> grant_count[1]=16'hFFFF and other counts unchanged.
